miss_handler: RTL
=================

MISS_HANDLER -- requirements
Module: miss_handler

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning CPU/cache/memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning data width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have CPU ports cpu_req in 1, cpu_we in 1, cpu_addr in ADDR_W, cpu_wdata in DATA_W.
REQ-006 SHALL have CPU ports cpu_ready out 1 (idle, can accept), cpu_valid out 1 (one-cycle completion), cpu_rdata out DATA_W, cpu_miss out 1 (completion needed a fill).
REQ-007 SHALL have cache ports c_addr out ADDR_W, c_din out DATA_W, c_we out 1, c_dout in DATA_W, c_hit in 1; the cache registers c_dout/c_hit one edge after a c_we=0 cycle.
REQ-008 SHALL have memory ports mem_req out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_ack in 1, mem_rdata in DATA_W (valid in the mem_ack cycle).
REQ-009 SHALL have ports hit_cnt out 16 and miss_cnt out 16, read-hit and read-miss statistics.

Function
REQ-010 SHALL implement FSM states IDLE, LOOKUP, CHECK, MEM, FILL, RESP.
REQ-011 IDLE: cpu_ready=1; cpu_req=1 at an edge latches addr/we/wdata; read -> LOOKUP, write -> MEM.
REQ-012 LOOKUP: c_addr=latched addr, c_we=0; always -> CHECK.
REQ-013 CHECK: c_hit=1 -> capture c_dout, cpu_miss=0, hit_cnt+1, -> RESP; c_hit=0 -> miss_cnt+1, -> MEM.
REQ-014 MEM: mem_req=1, mem_addr=latched addr, mem_we=latched we, mem_wdata=latched wdata, all held stable until mem_ack=1; at that edge, read captures mem_rdata and write captures wdata; -> FILL.
REQ-015 FILL: exactly one cycle of c_we=1, c_addr=latched addr, c_din=captured data; -> RESP.
REQ-016 RESP: cpu_valid=1 for exactly one cycle with cpu_rdata=captured data; cpu_miss=1 for read-miss and for write; -> IDLE.
REQ-017 Read-hit latency: cpu_valid SHALL be high in the cycle following the 3rd rising edge after the accepting edge (IDLE->LOOKUP->CHECK->RESP).
REQ-018 Read-miss with mem_ack in the first MEM cycle: cpu_valid SHALL be high after the 5th edge; each extra wait cycle adds one.
REQ-019 Writes are write-through, write-allocate; they are never counted as hit or miss.
REQ-020 cpu_ready SHALL be 0 outside IDLE; cpu_req outside IDLE is ignored, not queued.
REQ-021 mem_ack outside MEM SHALL be ignored; mem_req SHALL never assert outside MEM.
REQ-022 c_we SHALL be 1 only in FILL; c_addr SHALL equal latched addr in all non-IDLE states.
REQ-023 hit_cnt and miss_cnt SHALL saturate at 16'hFFFF and not wrap.
REQ-024 cpu_rdata SHALL hold its value between completions.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE; cpu_valid, cpu_miss, mem_req, mem_we, c_we = 0; cpu_rdata, latched addr/data, hit_cnt, miss_cnt = 0; cpu_ready = 1 once rst_n is high.
REQ-026 Reset mid-MEM SHALL drop mem_req without waiting for mem_ack; a late mem_ack SHALL be ignored.
REQ-027 Reset mid-FILL SHALL abort the cache write; no cpu_valid SHALL follow.

Structure
REQ-028 Package miss_handler_pkg SHALL hold the state enum, ADDR_W/DATA_W defaults and CNT_W=16.
REQ-029 Sub-module sat_counter (CNT_W wide, inc input, saturating, async active-low clear) SHALL be instantiated twice.
REQ-030 All outputs SHALL be driven from registers or directly from the state register; no combinational path from cpu_req to mem_req.

Verification
REQ-031 Read 0x005 into a cold cache, mem_ack immediate, mem_rdata=0xA5 -> mem_req 1 cycle, c_we with c_din=0xA5, cpu_valid after edge 5, cpu_miss=1, miss_cnt=1.
REQ-032 Repeat the read of 0x005 -> no mem_req, cpu_rdata=0xA5, cpu_miss=0, cpu_valid after edge 3, hit_cnt=1.
REQ-033 Write 0x085=0x3C, then read 0x085 -> mem_we=1 with mem_wdata=0x3C; read hits with 0x3C; counters change only on the read.
REQ-034 Read miss with mem_ack delayed 4 cycles; pulse cpu_req while busy -> mem_addr stable throughout, cpu_ready=0, extra request dropped, single cpu_valid.
REQ-035 Assert rst_n=0 during MEM, then raise mem_ack -> mem_req low asynchronously, no c_we, no cpu_valid, counters=0.
REQ-036 Preload miss_cnt to 0xFFFE via 3 misses in force mode -> counter reads 0xFFFF and stays there.

Source files
------------

// File: rtl/miss_handler_pkg.sv
// Shared types and sizing for the cache miss handler.
// Imported by the interface, the counter and the top.
package miss_handler_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 8;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM,
    FILL,
    RESP
  } state_t;

endpackage

// File: rtl/miss_handler_if.sv
// Memory-side request/acknowledge bus of the miss handler.
// master = miss handler, slave = backing memory.
interface miss_handler_if
  import miss_handler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/miss_handler_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter
  import miss_handler_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/miss_handler.sv
// Blocking single-request cache miss handler: lookup, memory
// fill / write-through, cache allocate, one-cycle completion.
module miss_handler
  import miss_handler_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_miss,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_din,
  output logic              c_we,
  input  logic [DATA_W-1:0] c_dout,
  input  logic              c_hit,
  miss_handler_if.master    mem,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic              miss_q;
  logic              hit_inc;
  logic              miss_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            state   <= cpu_we ? MEM : LOOKUP;
          end
        end
        LOOKUP: state <= CHECK;
        CHECK: begin
          if (c_hit) begin
            data_q  <= c_dout;
            rdata_q <= c_dout;
            miss_q  <= 1'b0;
            state   <= RESP;
          end else begin
            state <= MEM;
          end
        end
        MEM: begin
          // writes allocate their own data, reads take the fill
          if (mem.mem_ack) begin
            data_q <= we_q ? wdata_q : mem.mem_rdata;
            miss_q <= 1'b1;
            state  <= FILL;
          end
        end
        FILL: begin
          rdata_q <= data_q;
          state   <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_ready = (state == IDLE);
  assign cpu_valid = (state == RESP);
  assign cpu_miss  = cpu_valid & miss_q;
  assign cpu_rdata = rdata_q;

  assign c_addr = addr_q;
  assign c_din  = data_q;
  assign c_we   = (state == FILL);

  assign mem.mem_req   = (state == MEM);
  assign mem.mem_we    = (state == MEM) & we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign hit_inc  = (state == CHECK) & c_hit;
  assign miss_inc = (state == CHECK) & ~c_hit;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .cnt   (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .cnt   (miss_cnt)
  );

endmodule
